nn_layer_engine: RTL and testbench
==================================

Name: nn_layer_engine

Overview:
- Parametrised fully-connected layer engine for the MCU neural-network accelerator; successor to the fixed three-layer core.
- Executes one layer per command: first (input→hidden), middle (hidden→hidden) or last (hidden→output).
- Uses a single signed fixed-point MAC, one multiply per cycle, with an internal hidden-vector register chaining layers.
- Adds error reporting, saturation, an atomic output update and generic widths/node counts.

Parameters:
- DATA_W, 16: signed data/weight width, two's complement.
- FRAC_W, 8: fractional bits (Q(DATA_W-FRAC_W).FRAC_W).
- ACC_W, 40: accumulator width; must be ≥ 2*DATA_W + clog2(max fan-in).
- IN_NUM, 3: input nodes.
- HID_NUM, 3: hidden nodes.
- OUT_NUM, 10: output nodes.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only while ready=1.
- mode  in  2  0=first, 1=middle, 2=last, 3=reserved.
- in_vec  in  DATA_W*IN_NUM  input vector, element i at [i*DATA_W +: DATA_W].
- w_first  in  DATA_W*IN_NUM*HID_NUM  weight (out j, in i) at element j+HID_NUM*i.
- w_middle  in  DATA_W*HID_NUM*HID_NUM  weight (j,i) at element j+HID_NUM*i.
- w_last  in  DATA_W*HID_NUM*OUT_NUM  weight (j,i) at element j+OUT_NUM*i.
- ready  out  1  idle, command accepted.
- done  out  1  one-cycle pulse when a layer completes.
- err  out  1  one-cycle pulse when a command is rejected.
- hid_valid  out  1  hidden register holds a completed first/middle result.
- hid_vec  out  DATA_W*HID_NUM  current hidden vector.
- out_vec  out  DATA_W*OUT_NUM  final output vector.

Behaviour:
- Reset (synchronous, reset=1 at rising edge):
  - State goes to IDLE. ready=1. done=0, err=0, hid_valid=0.
  - hid_vec=0, out_vec=0, accumulator and counters cleared.
  - Reset mid-layer aborts the layer with no done pulse; partial results are discarded.
- States: IDLE, MAC, WRITE, DONE.
- IDLE, ready=1:
  - start=1 with mode 0, or mode 1/2 with hid_valid=1: latch mode, node j=0, input i=0, acc=0; go to MAC.
  - start=1 with mode 3, or mode 1/2 with hid_valid=0: err=1 for one cycle, stay in IDLE, no other state change.
- Inputs and weights must stay stable from the acceptance edge until done. The engine does not snapshot them.
- MAC:
  - Each cycle: acc += x[i]*w(j,i), full-precision signed product sign-extended to ACC_W.
  - x comes from in_vec (first) or the hidden register (middle/last).
  - Runs N_in cycles (IN_NUM for first, else HID_NUM), then goes to WRITE.
- WRITE:
  - r = acc >>> FRAC_W (arithmetic shift, truncation toward −inf).
  - Saturate r to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Store r into staging buffer element j, clear acc, i=0.
  - If j < N_out−1: j++, go to MAC. Otherwise go to DONE.
  - N_out is HID_NUM for first/middle, OUT_NUM for last.
- DONE (one cycle): done=1.
  - First/middle: copy staging buffer to hidden register and set hid_valid=1.
  - Last: copy staging buffer to out_vec; hid_valid is unchanged.
  - Next state IDLE; ready=1 in the following cycle.
- Atomic update: hid_vec and out_vec change only in DONE.
  - A middle layer reads the old hidden vector throughout, since the staging buffer is separate.
- While busy (ready=0): start is ignored and produces no err.
- Latency: done is high in the cycle beginning N_out*(N_in+1)+1 edges after the acceptance edge.
  - First: 3*(3+1)+1 = 13. Middle: 13. Last: 10*4+1 = 41.
- Throughput: a new start is accepted at the first edge after done falls; no back-to-back overlap.
- Repeated middle layers are permitted indefinitely.
- A new first layer overwrites the hidden register at its DONE.

Optional Feature:
- Macro: NN_RELU_EN.
- Defined: in WRITE for first/middle layers, a negative saturated result is replaced by 0. The last layer is never rectified.
- Undefined: results are stored as saturated signed values for all layers, with no activation.

Test Plan:
- Reset, then start mode=1 → err pulse of 1 cycle, ready stays 1, hid_valid=0, no done. Same for mode=3.
- First layer, in_vec=(0x0100, 0x0200, 0xFF00), w_first identity (0x0100 on j==i) → done at 13 cycles, hid_vec=(0x0100, 0x0200, 0xFF00). With NN_RELU_EN: (0x0100, 0x0200, 0x0000).
- Saturation: in_vec all 0x7F00, w_first all 0x7F00 → hid_vec all 0x7FFF. With in_vec all 0x8000 and weights all 0x7F00 → all 0x8000 without NN_RELU_EN, all 0x0000 with it.
- Middle in place: hidden=(1.0, 2.0, 3.0), w_middle = reverse permutation (w(j, 2−j) = 0x0100) → hidden=(0x0300, 0x0200, 0x0100), proving old values are read throughout.
- Last layer: hidden=(1.0, 1.0, 1.0), w_last(j,i) = j*0x0010 → out_vec[j] = j*0x0030, done at 41 cycles, hid_vec unchanged. A start pulsed mid-layer is ignored.
- Reset asserted at cycle 20 of a last layer → ready=1 next cycle, out_vec=0, hid_valid=0, no done pulse.

Source files
------------

// File: rtl/nn_layer_engine_if.sv
// rtl/nn_layer_engine_if.sv - command, operand and result bundle for nn_layer_engine
interface nn_layer_engine_if #(
    parameter int DATA_W  = 16,
    parameter int IN_NUM  = 3,
    parameter int HID_NUM = 3,
    parameter int OUT_NUM = 10
);
    logic                                start;
    logic [1:0]                          mode;
    logic [DATA_W*IN_NUM-1:0]            in_vec;
    logic [DATA_W*IN_NUM*HID_NUM-1:0]    w_first;
    logic [DATA_W*HID_NUM*HID_NUM-1:0]   w_middle;
    logic [DATA_W*HID_NUM*OUT_NUM-1:0]   w_last;
    logic                                ready;
    logic                                done;
    logic                                err;
    logic                                hid_valid;
    logic [DATA_W*HID_NUM-1:0]           hid_vec;
    logic [DATA_W*OUT_NUM-1:0]           out_vec;

    modport master (
        output start, mode, in_vec, w_first, w_middle, w_last,
        input  ready, done, err, hid_valid, hid_vec, out_vec
    );

    modport slave (
        input  start, mode, in_vec, w_first, w_middle, w_last,
        output ready, done, err, hid_valid, hid_vec, out_vec
    );
endinterface

// File: rtl/nn_layer_engine.sv
// rtl/nn_layer_engine.sv - single-MAC fully-connected layer engine with hidden-vector chaining
// Define NN_RELU_EN to rectify first/middle layer results.
module nn_layer_engine #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int ACC_W   = 40,
    parameter int IN_NUM  = 3,
    parameter int HID_NUM = 3,
    parameter int OUT_NUM = 10
) (
    input  logic             clk,
    input  logic             reset,
    nn_layer_engine_if.slave bus
);
    localparam int MAX_IO  = (IN_NUM > HID_NUM) ? IN_NUM : HID_NUM;
    localparam int MAX_NUM = (MAX_IO > OUT_NUM) ? MAX_IO : OUT_NUM;
    localparam int STG_NUM = (HID_NUM > OUT_NUM) ? HID_NUM : OUT_NUM;
    localparam int CNT_W   = $clog2(MAX_NUM + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;
    typedef enum logic [1:0] {M_FIRST = 2'd0, M_MIDDLE = 2'd1, M_LAST = 2'd2, M_RSVD = 2'd3} mode_t;

    state_t                      state;
    state_t                      state_nxt;
    mode_t                       mode_q;
    logic [CNT_W-1:0]            i_q;
    logic [CNT_W-1:0]            j_q;
    logic signed [ACC_W-1:0]     acc;
    logic [DATA_W*HID_NUM-1:0]   hid_q;
    logic [DATA_W*OUT_NUM-1:0]   out_q;
    logic [DATA_W*STG_NUM-1:0]   stage;
    logic                        hid_valid_q;
    logic                        done_q;
    logic                        err_q;

    logic                        legal;
    logic                        accept;
    logic                        reject;
    logic [CNT_W-1:0]            i_last;
    logic [CNT_W-1:0]            j_last;
    logic signed [DATA_W-1:0]    x_sel;
    logic signed [DATA_W-1:0]    w_sel;
    logic signed [2*DATA_W-1:0]  prod;
    logic signed [ACC_W-1:0]     prod_ext;
    logic signed [ACC_W-1:0]     shifted;
    logic signed [DATA_W-1:0]    res;

    assign legal = (bus.mode == 2'd0)
                || (((bus.mode == 2'd1) || (bus.mode == 2'd2)) && hid_valid_q);

    always_comb begin
        i_last = (mode_q == M_FIRST) ? CNT_W'(IN_NUM - 1) : CNT_W'(HID_NUM - 1);
        j_last = (mode_q == M_LAST)  ? CNT_W'(OUT_NUM - 1) : CNT_W'(HID_NUM - 1);
    end

    // Operand fetch: x(i) from the input port or the committed hidden register, w(j,i) by layer.
    always_comb begin
        x_sel = '0;
        w_sel = '0;
        if (mode_q == M_FIRST) begin
            x_sel = bus.in_vec[int'(i_q)*DATA_W +: DATA_W];
        end else begin
            x_sel = hid_q[int'(i_q)*DATA_W +: DATA_W];
        end
        case (mode_q)
            M_FIRST:  w_sel = bus.w_first[(int'(j_q) + HID_NUM*int'(i_q))*DATA_W +: DATA_W];
            M_MIDDLE: w_sel = bus.w_middle[(int'(j_q) + HID_NUM*int'(i_q))*DATA_W +: DATA_W];
            default:  w_sel = bus.w_last[(int'(j_q) + OUT_NUM*int'(i_q))*DATA_W +: DATA_W];
        endcase
    end

    assign prod     = x_sel * w_sel;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign shifted  = acc >>> FRAC_W;

    always_comb begin
        res = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[DATA_W-1:0];
        end
`ifdef NN_RELU_EN
        if ((mode_q != M_LAST) && res[DATA_W-1]) begin
            res = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (legal) begin
                        accept    = 1'b1;
                        state_nxt = S_MAC;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_MAC:   if (i_q == i_last) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (j_q == j_last) ? S_DONE : S_MAC;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Results land in the staging buffer; hid_q/out_q only change on the DONE edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= M_FIRST;
            i_q         <= '0;
            j_q         <= '0;
            acc         <= '0;
            hid_q       <= '0;
            out_q       <= '0;
            stage       <= '0;
            hid_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= reject;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode_q <= mode_t'(bus.mode);
                        i_q    <= '0;
                        j_q    <= '0;
                        acc    <= '0;
                    end
                end
                S_MAC: begin
                    acc <= acc + prod_ext;
                    i_q <= i_q + CNT_W'(1);
                end
                S_WRITE: begin
                    stage[int'(j_q)*DATA_W +: DATA_W] <= res;
                    acc <= '0;
                    i_q <= '0;
                    if (j_q != j_last) begin
                        j_q <= j_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    if (mode_q == M_LAST) begin
                        out_q <= stage[DATA_W*OUT_NUM-1:0];
                    end else begin
                        hid_q       <= stage[DATA_W*HID_NUM-1:0];
                        hid_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = (state == S_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.hid_valid = hid_valid_q;
    assign bus.hid_vec   = hid_q;
    assign bus.out_vec   = out_q;
endmodule

// File: tb/tb_nn_layer_engine.sv
// tb/tb_nn_layer_engine.sv - vector table, corner sequences and randomized model checks for nn_layer_engine
module tb_nn_layer_engine;
    localparam int DW  = 16;
    localparam int FW  = 8;
    localparam int AW  = 40;
    localparam int IN  = 3;
    localparam int HID = 3;
    localparam int OUT = 10;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    nn_layer_engine_if #(.DATA_W(DW), .IN_NUM(IN), .HID_NUM(HID), .OUT_NUM(OUT)) bus ();

    nn_layer_engine #(
        .DATA_W(DW), .FRAC_W(FW), .ACC_W(AW), .IN_NUM(IN), .HID_NUM(HID), .OUT_NUM(OUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] x_in  [IN];
    logic signed [DW-1:0] wf    [HID][IN];
    logic signed [DW-1:0] wm    [HID][HID];
    logic signed [DW-1:0] wl    [OUT][HID];
    logic signed [DW-1:0] m_hid [HID];
    logic signed [DW-1:0] m_out [OUT];
    bit                   m_hv;

    typedef struct packed {
        logic [2:0][DW-1:0] x;
        logic [DW-1:0]      wdiag;
        logic [DW-1:0]      woff;
        logic [2:0][DW-1:0] exp_plain;
        logic [2:0][DW-1:0] exp_relu;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [DW*OUT-1:0] act, input logic [DW*OUT-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < IN; i++) bus.in_vec[i*DW +: DW] = x_in[i];
        for (int j = 0; j < HID; j++)
            for (int i = 0; i < IN; i++) bus.w_first[(j + HID*i)*DW +: DW] = wf[j][i];
        for (int j = 0; j < HID; j++)
            for (int i = 0; i < HID; i++) bus.w_middle[(j + HID*i)*DW +: DW] = wm[j][i];
        for (int j = 0; j < OUT; j++)
            for (int i = 0; i < HID; i++) bus.w_last[(j + OUT*i)*DW +: DW] = wl[j][i];
    endtask

    // Reference: y[j] = sat(floor(sum_i x[i]*w(j,i) / 2^FW)), committed as a whole vector.
    task automatic model_layer(input int m);
        logic signed [DW-1:0] nxt [OUT];
        longint acc, r, xv, wv;
        int n_in, n_out;
        n_in  = (m == 0) ? IN : HID;
        n_out = (m == 2) ? OUT : HID;
        for (int j = 0; j < n_out; j++) begin
            acc = 0;
            for (int i = 0; i < n_in; i++) begin
                if (m == 0) begin
                    xv = longint'(x_in[i]);
                    wv = longint'(wf[j][i]);
                end else if (m == 1) begin
                    xv = longint'(m_hid[i]);
                    wv = longint'(wm[j][i]);
                end else begin
                    xv = longint'(m_hid[i]);
                    wv = longint'(wl[j][i]);
                end
                acc += xv * wv;
            end
            r = acc >>> FW;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
`ifdef NN_RELU_EN
            if (m != 2 && r < 0) r = 0;
`endif
            nxt[j] = DW'(r);
        end
        if (m == 2) begin
            for (int j = 0; j < OUT; j++) m_out[j] = nxt[j];
        end else begin
            for (int j = 0; j < HID; j++) m_hid[j] = nxt[j];
            m_hv = 1'b1;
        end
    endtask

    function automatic logic [DW*OUT-1:0] pack_hid();
        logic [DW*OUT-1:0] v;
        v = '0;
        for (int k = 0; k < HID; k++) v[k*DW +: DW] = m_hid[k];
        return v;
    endfunction

    function automatic logic [DW*OUT-1:0] pack_out();
        logic [DW*OUT-1:0] v;
        v = '0;
        for (int k = 0; k < OUT; k++) v[k*DW +: DW] = m_out[k];
        return v;
    endfunction

    function automatic logic signed [DW-1:0] rnd_val();
        int v;
        if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 65535));
        else v = int'($urandom_range(0, 1023)) - 512;
        return DW'(v);
    endfunction

    // Issues a command at the next edge and counts edges until done; bounded at 200.
    task automatic run_layer(input logic [1:0] m, input bit poke, input string name, output int lat);
        bit seen_err;
        bus.mode  = m;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat      = -1;
        seen_err = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (poke && k == 5) bus.start = 1'b1;
            if (poke && k == 6) bus.start = 1'b0;
            @(posedge clk); #1;
            if (k == 3) chk({name, "_busy_ready"}, bus.ready, 0);
            if (bus.err) seen_err = 1'b1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
        chk({name, "_busy_err"}, seen_err, 0);
    endtask

    task automatic run_and_check(input logic [1:0] m, input string name);
        int lat;
        int exp_lat;
        exp_lat = (m == 2) ? OUT*(HID+1)+1 : ((m == 0) ? HID*(IN+1)+1 : HID*(HID+1)+1);
        drive_inputs();
        model_layer(int'(m));
        run_layer(m, 1'b0, name, lat);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_hid"}, bus.hid_vec, pack_hid());
        chk({name, "_out"}, bus.out_vec, pack_out());
        chk({name, "_hid_valid"}, bus.hid_valid, m_hv);
    endtask

    task automatic reject_check(input logic [1:0] m, input string name);
        bus.mode  = m;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({name, "_err"}, bus.err, 1);
        chk({name, "_ready"}, bus.ready, 1);
        chk({name, "_done"}, bus.done, 0);
        @(posedge clk); #1;
        chk({name, "_err_fall"}, bus.err, 0);
        chk({name, "_hid_valid"}, bus.hid_valid, m_hv);
        chk({name, "_done2"}, bus.done, 0);
    endtask

    initial begin
        int lat;
        bit seen_done;
        logic [DW*OUT-1:0] exp_o;
        logic [2:0][DW-1:0] exp_h;

        tbl[0] = '{x: {16'hFF00, 16'h0200, 16'h0100}, wdiag: 16'h0100, woff: 16'h0000,
                   exp_plain: {16'hFF00, 16'h0200, 16'h0100}, exp_relu: {16'h0000, 16'h0200, 16'h0100}};
        tbl[1] = '{x: {16'h7F00, 16'h7F00, 16'h7F00}, wdiag: 16'h7F00, woff: 16'h7F00,
                   exp_plain: {16'h7FFF, 16'h7FFF, 16'h7FFF}, exp_relu: {16'h7FFF, 16'h7FFF, 16'h7FFF}};
        tbl[2] = '{x: {16'h8000, 16'h8000, 16'h8000}, wdiag: 16'h7F00, woff: 16'h7F00,
                   exp_plain: {16'h8000, 16'h8000, 16'h8000}, exp_relu: {16'h0000, 16'h0000, 16'h0000}};
        tbl[3] = '{x: {16'h0040, 16'hFF80, 16'h0180}, wdiag: 16'h0100, woff: 16'h0100,
                   exp_plain: {16'h0140, 16'h0140, 16'h0140}, exp_relu: {16'h0140, 16'h0140, 16'h0140}};
        tbl[4] = '{x: {16'h0000, 16'h0000, 16'hFFFF}, wdiag: 16'h0080, woff: 16'h0000,
                   exp_plain: {16'h0000, 16'h0000, 16'hFFFF}, exp_relu: {16'h0000, 16'h0000, 16'h0000}};

        for (int i = 0; i < IN; i++) x_in[i] = '0;
        for (int j = 0; j < HID; j++) for (int i = 0; i < IN; i++) wf[j][i] = '0;
        for (int j = 0; j < HID; j++) for (int i = 0; i < HID; i++) wm[j][i] = '0;
        for (int j = 0; j < OUT; j++) for (int i = 0; i < HID; i++) wl[j][i] = '0;
        for (int j = 0; j < HID; j++) m_hid[j] = '0;
        for (int j = 0; j < OUT; j++) m_out[j] = '0;
        m_hv      = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        drive_inputs();

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready", bus.ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_hid_valid", bus.hid_valid, 0);
        chk("rst_hid_vec", bus.hid_vec, 0);
        chk("rst_out_vec", bus.out_vec, 0);

        reject_check(2'd1, "rej_mid_novalid");
        reject_check(2'd3, "rej_rsvd");
        reject_check(2'd2, "rej_last_novalid");

        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < IN; i++) x_in[i] = tbl[n].x[i];
            for (int j = 0; j < HID; j++)
                for (int i = 0; i < IN; i++) wf[j][i] = (i == j) ? tbl[n].wdiag : tbl[n].woff;
            drive_inputs();
            model_layer(0);
            run_layer(2'd0, 1'b0, $sformatf("tbl%0d", n), lat);
`ifdef NN_RELU_EN
            exp_h = tbl[n].exp_relu;
`else
            exp_h = tbl[n].exp_plain;
`endif
            chk($sformatf("tbl%0d_latency", n), lat, 13);
            chk($sformatf("tbl%0d_hid", n), bus.hid_vec, exp_h);
            chk($sformatf("tbl%0d_hid_valid", n), bus.hid_valid, 1);
        end

        reject_check(2'd3, "rej_rsvd_valid");

        x_in = '{16'h0100, 16'h0200, 16'h0300};
        for (int j = 0; j < HID; j++) for (int i = 0; i < IN; i++) wf[j][i] = (i == j) ? 16'h0100 : 16'h0000;
        run_and_check(2'd0, "mid_setup");
        for (int j = 0; j < HID; j++) for (int i = 0; i < HID; i++) wm[j][i] = (i == 2 - j) ? 16'h0100 : 16'h0000;
        drive_inputs();
        model_layer(1);
        run_layer(2'd1, 1'b0, "mid_swap", lat);
        chk("mid_swap_latency", lat, 13);
        chk("mid_swap_hid", bus.hid_vec, 48'h0100_0200_0300);

        x_in = '{16'h0100, 16'h0100, 16'h0100};
        run_and_check(2'd0, "last_setup");
        for (int j = 0; j < OUT; j++) for (int i = 0; i < HID; i++) wl[j][i] = DW'(j * 16);
        drive_inputs();
        model_layer(2);
        run_layer(2'd2, 1'b1, "last", lat);
        exp_o = '0;
        for (int j = 0; j < OUT; j++) exp_o[j*DW +: DW] = DW'(j * 48);
        chk("last_latency", lat, 41);
        chk("last_out", bus.out_vec, exp_o);
        chk("last_hid_kept", bus.hid_vec, 48'h0100_0100_0100);
        chk("last_hid_valid", bus.hid_valid, 1);

        for (int it = 0; it < 30; it++) begin
            logic [1:0] m;
            m = m_hv ? 2'($urandom_range(0, 2)) : 2'd0;
            for (int i = 0; i < IN; i++) x_in[i] = rnd_val();
            for (int j = 0; j < HID; j++) for (int i = 0; i < IN; i++) wf[j][i] = rnd_val();
            for (int j = 0; j < HID; j++) for (int i = 0; i < HID; i++) wm[j][i] = rnd_val();
            for (int j = 0; j < OUT; j++) for (int i = 0; i < HID; i++) wl[j][i] = rnd_val();
            run_and_check(m, $sformatf("rnd%0d_m%0d", it, m));
        end

        drive_inputs();
        bus.mode  = 2'd2;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen_done = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", bus.ready, 1);
        chk("abort_out_vec", bus.out_vec, 0);
        chk("abort_hid_vec", bus.hid_vec, 0);
        chk("abort_hid_valid", bus.hid_valid, 0);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        chk("abort_no_done", seen_done, 0);
        m_hv = 1'b0;
        for (int j = 0; j < HID; j++) m_hid[j] = '0;
        for (int j = 0; j < OUT; j++) m_out[j] = '0;
        reject_check(2'd1, "rej_after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
